// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register in front of the ALU: operand forwarding, immediate
// generation, operand-2 selection and ALU control decode, all registered.
module ex_operand_stage #(
    parameter int n = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           id_valid,
    input  logic [31:0]    id_inst,
    input  logic [n-1:0]   id_rs1_data,
    input  logic [n-1:0]   id_rs2_data,
    input  logic           stall,
    input  logic           flush,
    input  logic           exm_reg_write,
    input  logic [4:0]     exm_rd,
    input  logic [n-1:0]   exm_data,
    input  logic           wb_reg_write,
    input  logic [4:0]     wb_rd,
    input  logic [n-1:0]   wb_data,
    output logic           ex_valid,
    output logic [31:0]    ex_inst,
    output logic [n-1:0]   ex_op1,
    output logic [n-1:0]   ex_op2,
    output logic [n-1:0]   ex_store_data,
    output logic [3:0]     ex_alu_ctrl,
    output logic [4:0]     ex_rd,
    output logic           ex_reg_write,
    output logic           ex_illegal
);

    typedef enum logic [6:0] {
        OP_R      = 7'b0110011,
        OP_I      = 7'b0010011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_BRANCH = 7'b1100011
    } opcode_e;

    typedef enum logic [3:0] {
        ALU_AND     = 4'b0000,
        ALU_OR      = 4'b0001,
        ALU_ADD     = 4'b0010,
        ALU_SLL     = 4'b0011,
        ALU_SLT     = 4'b0100,
        ALU_SLTU    = 4'b0101,
        ALU_SUB     = 4'b0110,
        ALU_XOR     = 4'b0111,
        ALU_SRL     = 4'b1000,
        ALU_SRA     = 4'b1010,
        ALU_ILLEGAL = 4'b1111
    } alu_ctrl_e;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // ------------------------------------------------------------------
    // Field extraction
    // ------------------------------------------------------------------
    logic [6:0]   w_opcode;
    logic [2:0]   w_funct3;
    logic [6:0]   w_funct7;
    logic [4:0]   w_rs1_idx;
    logic [4:0]   w_rs2_idx;
    logic [4:0]   w_rd_idx;
    logic [n-1:0] w_imm_i;
    logic [n-1:0] w_imm_s;
    logic [n-1:0] w_imm_shamt;

    assign w_opcode    = id_inst[6:0];
    assign w_funct3    = id_inst[14:12];
    assign w_funct7    = id_inst[31:25];
    assign w_rs1_idx   = id_inst[19:15];
    assign w_rs2_idx   = id_inst[24:20];
    assign w_rd_idx    = id_inst[11:7];
    assign w_imm_i     = {{(n-12){id_inst[31]}}, id_inst[31:20]};
    assign w_imm_s     = {{(n-12){id_inst[31]}}, id_inst[31:25], id_inst[11:7]};
    assign w_imm_shamt = {{(n-5){1'b0}}, id_inst[24:20]};

    // ------------------------------------------------------------------
    // Forwarding: the younger EX/MEM result beats MEM/WB; x0 is never forwarded
    // ------------------------------------------------------------------
    function automatic logic [n-1:0] fwd_sel(
        input logic [4:0]   src,
        input logic [n-1:0] rf_data,
        input logic         exm_we,
        input logic [4:0]   exm_dst,
        input logic [n-1:0] exm_val,
        input logic         wb_we,
        input logic [4:0]   wb_dst,
        input logic [n-1:0] wb_val
    );
        if (exm_we && (exm_dst != 5'd0) && (exm_dst == src)) begin
            return exm_val;
        end else if (wb_we && (wb_dst != 5'd0) && (wb_dst == src)) begin
            return wb_val;
        end
        return rf_data;
    endfunction

    logic [n-1:0] w_rs1_fwd;
    logic [n-1:0] w_rs2_fwd;

    assign w_rs1_fwd = fwd_sel(w_rs1_idx, id_rs1_data, exm_reg_write, exm_rd, exm_data,
                               wb_reg_write, wb_rd, wb_data);
    assign w_rs2_fwd = fwd_sel(w_rs2_idx, id_rs2_data, exm_reg_write, exm_rd, exm_data,
                               wb_reg_write, wb_rd, wb_data);

    // ALU code shared by R-type and I-type for the funct7=0 encodings
    function automatic alu_ctrl_e base_ctrl(input logic [2:0] f3);
        case (f3)
            3'b000:  return ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Decode and operand-2 selection
    // ------------------------------------------------------------------
    alu_ctrl_e    w_alu_ctrl;
    logic [n-1:0] w_op2;
    logic         w_writes_rd;
    logic         w_illegal;
    logic         w_reg_write;

    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        w_alu_ctrl  = ALU_ILLEGAL;
        w_op2       = w_rs2_fwd;
        w_writes_rd = 1'b0;

        case (w_opcode)
            OP_R: begin
                w_writes_rd = 1'b1;
                if (w_funct7 == F7_ZERO) begin
                    w_alu_ctrl = base_ctrl(w_funct3);
                end else if (w_funct7 == F7_ALT && w_funct3 == 3'b000) begin
                    w_alu_ctrl = ALU_SUB;
                end else if (w_funct7 == F7_ALT && w_funct3 == 3'b101) begin
                    w_alu_ctrl = ALU_SRA;
                end
            end
            OP_I: begin
                w_writes_rd = 1'b1;
                w_op2       = w_imm_i;
                case (w_funct3)
                    3'b001: begin
                        w_op2 = w_imm_shamt;
                        if (w_funct7 == F7_ZERO) w_alu_ctrl = ALU_SLL;
                    end
                    3'b101: begin
                        w_op2 = w_imm_shamt;
                        if (w_funct7 == F7_ZERO)     w_alu_ctrl = ALU_SRL;
                        else if (w_funct7 == F7_ALT) w_alu_ctrl = ALU_SRA;
                    end
                    default: w_alu_ctrl = base_ctrl(w_funct3);
                endcase
            end
            OP_LOAD: begin
                w_writes_rd = 1'b1;
                w_op2       = w_imm_i;
                w_alu_ctrl  = ALU_ADD;
            end
            OP_STORE: begin
                w_op2      = w_imm_s;
                w_alu_ctrl = ALU_ADD;
            end
            OP_BRANCH: begin
                w_alu_ctrl = ALU_SUB;
            end
            default: ;
        endcase

        // ALU_ILLEGAL is never a legal result, so it doubles as the illegal flag
        w_illegal   = (w_alu_ctrl == ALU_ILLEGAL);
        w_reg_write = id_valid && w_writes_rd && !w_illegal && (w_rd_idx != 5'd0);
    end

    // ------------------------------------------------------------------
    // EX-stage registers
    // ------------------------------------------------------------------
    logic         r_valid;
    logic [31:0]  r_inst;
    logic [n-1:0] r_op1;
    logic [n-1:0] r_op2;
    logic [n-1:0] r_store_data;
    logic [3:0]   r_alu_ctrl;
    logic [4:0]   r_rd;
    logic         r_reg_write;
    logic         r_illegal;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid      <= 1'b0;
            r_inst       <= '0;
            r_op1        <= '0;
            r_op2        <= '0;
            r_store_data <= '0;
            r_alu_ctrl   <= 4'b0000;
            r_rd         <= '0;
            r_reg_write  <= 1'b0;
            r_illegal    <= 1'b0;
        end else if (flush) begin
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
            r_illegal   <= 1'b0;
        end else if (!stall) begin
            r_valid      <= id_valid;
            r_inst       <= id_inst;
            r_op1        <= w_rs1_fwd;
            r_op2        <= w_op2;
            r_store_data <= w_rs2_fwd;
            r_alu_ctrl   <= w_alu_ctrl;
            r_rd         <= w_rd_idx;
            r_reg_write  <= w_reg_write;
            r_illegal    <= id_valid && w_illegal;
        end
    end

    assign ex_valid      = r_valid;
    assign ex_inst       = r_inst;
    assign ex_op1        = r_op1;
    assign ex_op2        = r_op2;
    assign ex_store_data = r_store_data;
    assign ex_alu_ctrl   = r_alu_ctrl;
    assign ex_rd         = r_rd;
    assign ex_reg_write  = r_reg_write;
    assign ex_illegal    = r_illegal;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Scoreboard bench for ex_operand_stage: expectations are queued as stimulus is
// driven and compared (under a field mask) one cycle later.
module tb_ex_operand_stage;

    localparam int n = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          id_valid;
    logic [31:0]   id_inst;
    logic [n-1:0]  id_rs1_data, id_rs2_data;
    logic          stall, flush;
    logic          exm_reg_write, wb_reg_write;
    logic [4:0]    exm_rd, wb_rd;
    logic [n-1:0]  exm_data, wb_data;
    logic          ex_valid, ex_reg_write, ex_illegal;
    logic [31:0]   ex_inst;
    logic [n-1:0]  ex_op1, ex_op2, ex_store_data;
    logic [3:0]    ex_alu_ctrl;
    logic [4:0]    ex_rd;

    ex_operand_stage #(.n(n)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_inst(id_inst),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .stall(stall), .flush(flush),
        .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_data(exm_data),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_inst(ex_inst), .ex_op1(ex_op1), .ex_op2(ex_op2),
        .ex_store_data(ex_store_data), .ex_alu_ctrl(ex_alu_ctrl), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_illegal(ex_illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          valid;
        logic [31:0]   inst;
        logic [n-1:0]  op1;
        logic [n-1:0]  op2;
        logic [n-1:0]  store;
        logic [3:0]    ctrl;
        logic [4:0]    rd;
        logic          rw;
        logic          ill;
    } out_t;

    typedef struct {
        out_t  val;
        out_t  mask;
        string name;
    } sb_t;

    sb_t  sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    out_t m_all, m_ctrl, m_kill;

    // ---------------- encoders and helpers ----------------
    function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                          logic [2:0] f3, logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                          logic [4:0] rd, logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(logic [11:0] imm, logic [4:0] rs2, logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction

    function automatic out_t mk(logic v, logic [31:0] inst, logic [n-1:0] op1, logic [n-1:0] op2,
                                logic [n-1:0] st, logic [3:0] ctrl, logic [4:0] rd,
                                logic rw, logic ill);
        out_t o;
        o.valid = v; o.inst = inst; o.op1 = op1; o.op2 = op2; o.store = st;
        o.ctrl = ctrl; o.rd = rd; o.rw = rw; o.ill = ill;
        return o;
    endfunction

    function automatic out_t observed();
        return mk(ex_valid, ex_inst, ex_op1, ex_op2, ex_store_data, ex_alu_ctrl,
                  ex_rd, ex_reg_write, ex_illegal);
    endfunction

    task automatic drive(logic v, logic [31:0] inst, logic [n-1:0] d1, logic [n-1:0] d2);
        id_valid = v; id_inst = inst; id_rs1_data = d1; id_rs2_data = d2;
    endtask

    task automatic fwd(logic ew, logic [4:0] erd, logic [n-1:0] ed,
                       logic ww, logic [4:0] wrd, logic [n-1:0] wd);
        exm_reg_write = ew; exm_rd = erd; exm_data = ed;
        wb_reg_write = ww; wb_rd = wrd; wb_data = wd;
    endtask

    task automatic expect_out(out_t v, out_t m, string name);
        sb.push_back('{val: v, mask: m, name: name});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        sb_t e;
        rst_n = 1'b1;
        drive(1'b1, enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd9), 32'h1234, 32'h5678);
        tick();
        #2;
        rst_n = 1'b0;
        expect_out('0, m_all, "async_reset");
        #1;
        e = sb.pop_front();
        n_checks++;
        if (((observed() ^ e.val) & e.mask) !== '0) begin
            n_errors++;
            $display("FAIL %s: got %h required %h", e.name, observed(), e.val);
        end
        #1;
        rst_n = 1'b1;
        drive(1'b1, enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), 32'd5, 32'd7);
        expect_out(mk(1, enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), 5, 7, 7, 4'b0010, 3, 1, 0),
                   m_all, "add_after_reset");
        tick();
        e = sb.pop_front();
        n_checks++;
        if (((observed() ^ e.val) & e.mask) !== '0) begin
            n_errors++;
            $display("FAIL %s: got %h required %h", e.name, observed(), e.val);
        end
    endtask

    task automatic test_forwarding();
        sb_t e;
        logic [31:0] sub = enc_r(7'h20, 5'd1, 5'd1, 3'b000, 5'd4);
        logic [31:0] add6 = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd6);
        logic [31:0] add0 = enc_r(7'h00, 5'd0, 5'd0, 3'b000, 5'd5);
        for (int k = 0; k < 5; k++) begin
            case (k)
                0: begin
                    drive(1, sub, 32'h11, 32'h22); fwd(1, 5'd1, 32'hAA, 1, 5'd1, 32'hBB);
                    expect_out(mk(1, sub, 32'hAA, 32'hAA, 32'hAA, 4'b0110, 4, 1, 0), m_all, "fwd_exm_wins");
                end
                1: begin
                    drive(1, sub, 32'h11, 32'h22); fwd(1, 5'd0, 32'hAA, 1, 5'd1, 32'hBB);
                    expect_out(mk(1, sub, 32'hBB, 32'hBB, 32'hBB, 4'b0110, 4, 1, 0), m_all, "fwd_wb_exm_x0");
                end
                2: begin
                    drive(1, add6, 32'h11, 32'h22); fwd(1, 5'd2, 32'hAA, 1, 5'd1, 32'hBB);
                    expect_out(mk(1, add6, 32'hBB, 32'hAA, 32'hAA, 4'b0010, 6, 1, 0), m_all, "fwd_split");
                end
                3: begin
                    drive(1, add0, 32'h11, 32'h22); fwd(1, 5'd0, 32'hAA, 1, 5'd0, 32'hBB);
                    expect_out(mk(1, add0, 32'h11, 32'h22, 32'h22, 4'b0010, 5, 1, 0), m_all, "fwd_never_x0");
                end
                default: begin
                    drive(1, add6, 32'h11, 32'h22); fwd(0, 5'd1, 32'hAA, 0, 5'd2, 32'hBB);
                    expect_out(mk(1, add6, 32'h11, 32'h22, 32'h22, 4'b0010, 6, 1, 0), m_all, "fwd_no_write");
                end
            endcase
            tick();
            e = sb.pop_front();
            n_checks++;
            if (((observed() ^ e.val) & e.mask) !== '0) begin
                n_errors++;
                $display("FAIL %s: got %h required %h", e.name, observed(), e.val);
            end
        end
        fwd(0, 5'd0, '0, 0, 5'd0, '0);
    endtask

    task automatic test_immediates();
        sb_t e;
        logic [31:0] insts[5];
        out_t        exps[5];
        string       names[5];
        insts[0] = enc_i(12'hFFF, 5'd1, 3'b000, 5'd7, 7'b0010011);
        exps[0]  = mk(1, insts[0], 10, 32'hFFFF_FFFF, 20, 4'b0010, 7, 1, 0);
        names[0] = "addi_neg1";
        insts[1] = enc_i({7'b0100000, 5'd5}, 5'd1, 3'b101, 5'd8, 7'b0010011);
        exps[1]  = mk(1, insts[1], 10, 32'd5, 20, 4'b1010, 8, 1, 0);
        names[1] = "srai_5";
        insts[2] = enc_s(12'hFFC, 5'd2, 5'd1);
        exps[2]  = mk(1, insts[2], 10, 32'hFFFF_FFFC, 20, 4'b0010, 5'd28, 0, 0);
        names[2] = "sw_minus4";
        insts[3] = enc_i(12'h008, 5'd1, 3'b010, 5'd9, 7'b0000011);
        exps[3]  = mk(1, insts[3], 10, 32'd8, 20, 4'b0010, 9, 1, 0);
        names[3] = "lw_8";
        insts[4] = {7'b0, 5'd2, 5'd1, 3'b000, 5'd0, 7'b1100011};
        exps[4]  = mk(1, insts[4], 10, 20, 20, 4'b0110, 0, 0, 0);
        names[4] = "beq";
        for (int k = 0; k < 5; k++) begin
            drive(1, insts[k], 32'd10, 32'd20);
            expect_out(exps[k], m_all, names[k]);
            tick();
            e = sb.pop_front();
            n_checks++;
            if (((observed() ^ e.val) & e.mask) !== '0) begin
                n_errors++;
                $display("FAIL %s: got %h required %h", e.name, observed(), e.val);
            end
        end
    endtask

    task automatic test_back_to_back();
        sb_t e;
        // {f7, f3, expected ctrl} for every R-type encoding
        logic [6:0] r_f7[10]   = '{7'h00, 7'h20, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h20, 7'h00, 7'h00};
        logic [2:0] r_f3[10]   = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5, 3'd6, 3'd7};
        logic [3:0] r_ctl[10]  = '{4'h2, 4'h6, 4'h3, 4'h4, 4'h5, 4'h7, 4'h8, 4'hA, 4'h1, 4'h0};
        // {imm12, f3, expected op2, expected ctrl} for I-type ALU encodings
        logic [11:0] i_imm[8]  = '{12'h123, 12'h800, 12'h7FF, 12'hFFF, 12'h001, 12'h0F0, 12'h01F, 12'h001};
        logic [2:0]  i_f3[8]   = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd6, 3'd7, 3'd1, 3'd5};
        logic [31:0] i_op2[8]  = '{32'h123, 32'hFFFF_F800, 32'h7FF, 32'hFFFF_FFFF, 32'h1, 32'hF0, 32'd31, 32'd1};
        logic [3:0]  i_ctl[8]  = '{4'h2, 4'h4, 4'h5, 4'h7, 4'h1, 4'h0, 4'h3, 4'h8};
        logic [31:0] inst;
        for (int k = 0; k < 18; k++) begin
            if (k < 10) begin
                inst = enc_r(r_f7[k], 5'd2, 5'd1, r_f3[k], 5'(k + 1));
                drive(1, inst, 32'h1000 + k, 32'h2000 + k);
                expect_out(mk(1, inst, 32'h1000 + k, 32'h2000 + k, 32'h2000 + k, r_ctl[k],
                              5'(k + 1), 1, 0), m_all, $sformatf("rtype_%0d", k));
            end else begin
                inst = enc_i(i_imm[k-10], 5'd3, i_f3[k-10], 5'(k + 1), 7'b0010011);
                drive(1, inst, 32'h1000 + k, 32'h2000 + k);
                expect_out(mk(1, inst, 32'h1000 + k, i_op2[k-10], 32'h2000 + k, i_ctl[k-10],
                              5'(k + 1), 1, 0), m_all, $sformatf("itype_%0d", k - 10));
            end
            tick();
            e = sb.pop_front();
            n_checks++;
            if (((observed() ^ e.val) & e.mask) !== '0) begin
                n_errors++;
                $display("FAIL %s: got %h required %h", e.name, observed(), e.val);
            end
        end
    endtask

    task automatic test_stall_flush();
        sb_t  e;
        logic [31:0] xor_i = enc_r(7'h00, 5'd2, 5'd1, 3'b100, 5'd10);
        out_t held = mk(1, xor_i, 32'h55, 32'h0F, 32'h0F, 4'b0111, 10, 1, 0);
        for (int k = 0; k < 6; k++) begin
            stall = 1'b0; flush = 1'b0;
            case (k)
                0: begin
                    drive(1, xor_i, 32'h55, 32'h0F);
                    expect_out(held, m_all, "xor_capture");
                end
                1, 2, 3: begin
                    stall = 1'b1;
                    drive(1, enc_i(12'h7FF, 5'd1, 3'b000, 5'(k), 7'b0010011), 32'h99 + k, 32'h77);
                    fwd(1, 5'd1, 32'hDEAD, 1, 5'd2, 32'hBEEF);
                    expect_out(held, m_all, $sformatf("stall_hold_%0d", k));
                end
                4: begin
                    stall = 1'b1; flush = 1'b1;
                    drive(1, xor_i, 32'h55, 32'h0F);
                    expect_out(mk(0, '0, '0, '0, '0, '0, '0, 0, 0), m_kill, "stall_flush");
                end
                default: begin
                    flush = 1'b1;
                    drive(1, {25'h0, 7'b0110111}, 32'h1, 32'h2);
                    expect_out(mk(0, '0, '0, '0, '0, '0, '0, 0, 0), m_kill, "flush_illegal");
                end
            endcase
            tick();
            e = sb.pop_front();
            n_checks++;
            if (((observed() ^ e.val) & e.mask) !== '0) begin
                n_errors++;
                $display("FAIL %s: got %h required %h", e.name, observed(), e.val);
            end
        end
        stall = 1'b0; flush = 1'b0;
        fwd(0, 5'd0, '0, 0, 5'd0, '0);
    endtask

    task automatic test_illegal();
        sb_t e;
        logic [31:0] add_x0 = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd0);
        for (int k = 0; k < 6; k++) begin
            case (k)
                0: begin
                    drive(1, {20'hABCDE, 5'd3, 7'b0110111}, 1, 2);
                    expect_out(mk(1, '0, '0, '0, '0, 4'hF, '0, 0, 1), m_ctrl, "lui_illegal");
                end
                1: begin
                    drive(1, enc_r(7'h01, 5'd2, 5'd1, 3'b000, 5'd3), 1, 2);
                    expect_out(mk(1, '0, '0, '0, '0, 4'hF, '0, 0, 1), m_ctrl, "r_f7_01");
                end
                2: begin
                    drive(1, enc_r(7'h20, 5'd2, 5'd1, 3'b001, 5'd3), 1, 2);
                    expect_out(mk(1, '0, '0, '0, '0, 4'hF, '0, 0, 1), m_ctrl, "r_sll_alt");
                end
                3: begin
                    drive(1, enc_i({7'h20, 5'd3}, 5'd1, 3'b001, 5'd3, 7'b0010011), 1, 2);
                    expect_out(mk(1, '0, '0, '0, '0, 4'hF, '0, 0, 1), m_ctrl, "slli_bad_f7");
                end
                4: begin
                    drive(1, add_x0, 32'h31, 32'h32);
                    expect_out(mk(1, add_x0, 32'h31, 32'h32, 32'h32, 4'b0010, 0, 0, 0), m_all, "add_x0");
                end
                default: begin
                    drive(0, {25'h0, 7'b0110111}, 1, 2);
                    expect_out(mk(0, '0, '0, '0, '0, '0, '0, 0, 0), m_kill, "invalid_slot");
                end
            endcase
            tick();
            e = sb.pop_front();
            n_checks++;
            if (((observed() ^ e.val) & e.mask) !== '0) begin
                n_errors++;
                $display("FAIL %s: got %h required %h", e.name, observed(), e.val);
            end
        end
    endtask

    initial begin
        m_all  = '1;
        m_ctrl = mk(1, '0, '0, '0, '0, 4'hF, '0, 1, 1);
        m_kill = mk(1, '0, '0, '0, '0, '0, '0, 1, 1);
        rst_n = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        drive(0, '0, '0, '0);
        fwd(0, 5'd0, '0, 0, 5'd0, '0);
        tick();
        test_reset();
        test_forwarding();
        test_immediates();
        test_back_to_back();
        test_stall_flush();
        test_illegal();
        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d entries required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
ID/EX pipeline register that feeds the ALU. It captures the decoded instruction and register-file operands and resolves data hazards by forwarding from the EX/MEM and MEM/WB stages. It generates the immediate and selects operand 2, then decodes the 4-bit ALU control code. All of these are presented as registered outputs to the ALU inputs (rs1, rs2, inst, alu_ctrl). It also honours stall and flush requests from the hazard unit.

Parameters:
- n, 32, datapath width of operands, forwarded data and immediates (must be >= 12).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_valid  in  1  decode stage holds a valid instruction.
- id_inst  in  32  instruction word from decode.
- id_rs1_data  in  n  register-file read data for inst[19:15].
- id_rs2_data  in  n  register-file read data for inst[24:20].
- stall  in  1  hold all EX-stage registers.
- flush  in  1  kill the instruction entering EX (branch/jump redirect).
- exm_reg_write  in  1  EX/MEM instruction writes a register.
- exm_rd  in  5  EX/MEM destination register.
- exm_data  in  n  EX/MEM result.
- wb_reg_write  in  1  MEM/WB instruction writes a register.
- wb_rd  in  5  MEM/WB destination register.
- wb_data  in  n  MEM/WB write-back data.
- ex_valid  out  1  EX holds a live instruction.
- ex_inst  out  32  instruction word to ALU inst.
- ex_op1  out  n  operand to ALU rs1.
- ex_op2  out  n  operand to ALU rs2 (register value or immediate).
- ex_store_data  out  n  forwarded rs2 value, used by stores.
- ex_alu_ctrl  out  4  ALU control code.
- ex_rd  out  5  destination register.
- ex_reg_write  out  1  instruction writes rd.
- ex_illegal  out  1  unsupported encoding captured.

Behaviour:
- Reset (rst_n=0, asynchronous, effective immediately even mid-cycle): all outputs 0, ex_alu_ctrl=4'b0000.
- Update rule at each rising edge when rst_n=1:
  - If flush: ex_valid<=0, ex_reg_write<=0, ex_illegal<=0. Other fields are don't-care. Flush has priority over stall.
  - Else if stall: all outputs hold their values.
  - Else: capture. ex_valid<=id_valid. When id_valid=0, ex_reg_write<=0 and ex_illegal<=0.
- Latency: exactly 1 cycle from decode inputs to outputs. Forwarding is resolved combinationally in the capture cycle only; held values are not re-forwarded during a stall.
- Forwarding, rs1=inst[19:15] (rs2=inst[24:20] identical):
  - If exm_reg_write && exm_rd!=0 && exm_rd==rs1: use exm_data.
  - Else if wb_reg_write && wb_rd!=0 && wb_rd==rs1: use wb_data.
  - Else: use id_rs1_data.
  - EX/MEM wins when both stages match. Register x0 is never forwarded.
- Immediates, sign-extended to n bits:
  - I-type: inst[31:20].
  - S-type: {inst[31:25],inst[11:7]}.
  - Shift-immediate: inst[24:20], zero-extended.
- Decode by opcode (f3=inst[14:12], f7=inst[31:25]):
  - 0110011 R-type: op2=rs2.
    - f3 000: f7=0 → 0010, f7=0100000 → 0110.
    - f3 001 → 0011; 010 → 0100; 011 → 0101; 100 → 0111.
    - f3 101: f7=0 → 1000, f7=0100000 → 1010.
    - f3 110 → 0001; 111 → 0000.
    - Any other f7 → illegal.
  - 0010011 I-type: op2=imm.
    - ADDI 0010, SLTI 0100, SLTIU 0101, XORI 0111, ORI 0001, ANDI 0000.
    - SLLI 0011 (f7 must be 0).
    - SRLI 1000 when f7=0; SRAI 1010 when f7=0100000; other f7 → illegal.
  - 0000011 load: 0010, op2=I-imm.
  - 0100011 store: 0010, op2=S-imm, reg_write=0.
  - 1100011 branch: 0110, op2=rs2, reg_write=0.
  - Any other opcode: illegal.
- Illegal instruction: ex_illegal=1, ex_alu_ctrl=4'b1111, ex_reg_write=0.
- ex_reg_write is forced to 0 when rd=inst[11:7]=0.
- ex_store_data always carries the forwarded rs2 value, regardless of opcode.

Test Plan:
- Reset check: rst_n low asynchronously between clocks → all outputs 0 immediately. Release, then id_valid=1 with ADD x3,x1,x2 (id_rs1_data=5, id_rs2_data=7) → next cycle ex_valid=1, ex_op1=5, ex_op2=7, ex_alu_ctrl=0010, ex_rd=3, ex_reg_write=1.
- Forwarding priority: SUB x4,x1,x1 with exm_rd=1/exm_data=0xAA, wb_rd=1/wb_data=0xBB, both reg_write=1 → ex_op1=ex_op2=0xAA, ex_alu_ctrl=0110. Repeat with exm_rd=0 → both operands 0xBB.
- Immediate paths: ADDI with imm=0xFFF → ex_op2=0xFFFFFFFF. SRAI shamt=5 → ex_op2=5, ex_alu_ctrl=1010. SW with imm=-4 → ex_op2=0xFFFFFFFC, ex_reg_write=0.
- Stall then flush: capture XOR; assert stall 3 cycles while changing id_* inputs → outputs unchanged. Assert stall and flush together → ex_valid=0 next cycle.
- Illegal and x0 cases: opcode 0110111 → ex_illegal=1, ex_alu_ctrl=1111, ex_reg_write=0. R-type with f7=0000001 → ex_illegal=1. ADD x0,... → ex_reg_write=0.
